// File: rtl/noc_inject_arbiter_pkg.sv
// Shared definitions for the NoC injection arbiter: state encoding, default
// widths from the NoC parameter header, and flit field placement helpers.
package noc_inject_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ         = 4;
  localparam int unsigned DEF_FLIT_DATA_WIDTH = 64;
  localparam int unsigned DEF_DEST_BITS       = 5;
  localparam int unsigned DEF_VC_BITS         = 2;
  localparam int unsigned DEF_TX_VC           = 0;
  localparam int unsigned DEF_CREDIT_INIT     = 16;
  localparam int unsigned DEF_CNT_BITS        = 5;
  localparam int unsigned GRANT_BITS          = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } arb_state_e;

  // Flit word layout, MSB first: {valid, tail, dest, vc, data}
  function automatic int unsigned vc_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned dest_lsb(input int unsigned data_w, input int unsigned vc_w);
    return data_w + vc_w;
  endfunction

  function automatic int unsigned tail_pos(input int unsigned data_w, input int unsigned vc_w,
                                           input int unsigned dest_w);
    return data_w + vc_w + dest_w;
  endfunction

  function automatic int unsigned valid_pos(input int unsigned data_w, input int unsigned vc_w,
                                            input int unsigned dest_w);
    return data_w + vc_w + dest_w + 1;
  endfunction

  function automatic int unsigned credit_valid_pos(input int unsigned vc_w);
    return vc_w;
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above ptr, with wrap.
module rr_pick
  import noc_inject_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned IDX_BITS = GRANT_BITS
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [IDX_BITS-1:0] idx,
  output logic                found
);

  int unsigned ptr_i;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    ptr_i = 32'(ptr);
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (j == ((ptr_i + k) % NUM_REQ))) begin
          found = 1'b1;
          idx   = IDX_BITS'(j);
        end
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-atomic round-robin arbiter sharing one NoC send port; owns the port credits.
// Optional macro ARB_PRIO0_EN gives requester 0 strict priority at arbitration.
module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = DEF_NUM_REQ,
  parameter int unsigned FLIT_DATA_WIDTH = DEF_FLIT_DATA_WIDTH,
  parameter int unsigned DEST_BITS       = DEF_DEST_BITS,
  parameter int unsigned VC_BITS         = DEF_VC_BITS,
  parameter int unsigned TX_VC           = DEF_TX_VC,
  parameter int unsigned CREDIT_INIT     = DEF_CREDIT_INIT,
  parameter int unsigned CNT_BITS        = DEF_CNT_BITS
) (
  input  logic                                      sys_clk,
  input  logic                                      reset,
  input  logic [NUM_REQ-1:0]                        req_valid,
  input  logic [NUM_REQ-1:0]                        req_tail,
  input  logic [NUM_REQ*DEST_BITS-1:0]              req_dest,
  input  logic [NUM_REQ*FLIT_DATA_WIDTH-1:0]        req_data,
  output logic [NUM_REQ-1:0]                        req_ready,
  output logic [2+FLIT_DATA_WIDTH+DEST_BITS+VC_BITS-1:0] putFlit,
  output logic                                      EN_putFlit,
  input  logic [VC_BITS:0]                          getCredits,
  output logic                                      EN_getCredits,
  output logic [2:0]                                grant_id,
  output logic                                      busy,
  output logic                                      credit_err
);

  localparam int unsigned FLIT_W         = 2 + FLIT_DATA_WIDTH + DEST_BITS + VC_BITS;
  localparam int unsigned VALID_POS      = valid_pos(FLIT_DATA_WIDTH, VC_BITS, DEST_BITS);
  localparam int unsigned TAIL_POS       = tail_pos(FLIT_DATA_WIDTH, VC_BITS, DEST_BITS);
  localparam int unsigned DEST_LSB       = dest_lsb(FLIT_DATA_WIDTH, VC_BITS);
  localparam int unsigned VC_LSB         = vc_lsb(FLIT_DATA_WIDTH);
  localparam int unsigned CRED_VALID_POS = credit_valid_pos(VC_BITS);

  arb_state_e                 state_q, state_d;
  logic [GRANT_BITS-1:0]      grant_q, grant_d;
  logic [GRANT_BITS-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_BITS-1:0]        credits_q, credits_d;
  logic [FLIT_W-1:0]          flit_q, flit_d;
  logic                       en_q, en_d;
  logic                       cerr_q, cerr_d;

  logic [NUM_REQ-1:0]         pick_req;
  logic [GRANT_BITS-1:0]      pick_idx, arb_idx;
  logic                       pick_found, arb_found;
  logic                       cur_valid, cur_tail, accept, credit_in;
  logic [DEST_BITS-1:0]       cur_dest;
  logic [FLIT_DATA_WIDTH-1:0] cur_data;
  logic                       unused_cred_vc;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_BITS (GRANT_BITS)
  ) u_rr_pick (
    .req   (pick_req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

`ifdef ARB_PRIO0_EN
  // Requester 0 bypasses the rotating search; the others still round-robin.
  assign pick_req = {req_valid[NUM_REQ-1:1], 1'b0};

  always_comb begin
    arb_found = pick_found;
    arb_idx   = pick_idx;
    if (req_valid[0]) begin
      arb_found = 1'b1;
      arb_idx   = '0;
    end
  end
`else
  assign pick_req  = req_valid;
  assign arb_found = pick_found;
  assign arb_idx   = pick_idx;
`endif

  assign credit_in      = getCredits[CRED_VALID_POS];
  assign unused_cred_vc = ^getCredits[VC_BITS-1:0];

  always_comb begin
    cur_valid = 1'b0;
    cur_tail  = 1'b0;
    cur_dest  = '0;
    cur_data  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GRANT_BITS'(i)) begin
        cur_valid    = req_valid[i];
        cur_tail     = req_tail[i];
        cur_dest     = req_dest[i*DEST_BITS +: DEST_BITS];
        cur_data     = req_data[i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
        req_ready[i] = (state_q == SEND) && (credits_q != '0);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    credits_d = credits_q;
    cerr_d    = cerr_q;
    en_d      = 1'b0;
    flit_d    = '0;
    accept    = (state_q == SEND) && cur_valid && (credits_q != '0);

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept && cur_tail) begin
          rr_ptr_d = (grant_q == GRANT_BITS'(NUM_REQ - 1)) ? '0 : grant_q + GRANT_BITS'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      en_d                                  = 1'b1;
      flit_d[VALID_POS]                     = 1'b1;
      flit_d[TAIL_POS]                      = cur_tail;
      flit_d[DEST_LSB +: DEST_BITS]         = cur_dest;
      flit_d[VC_LSB +: VC_BITS]             = VC_BITS'(TX_VC);
      flit_d[0 +: FLIT_DATA_WIDTH]          = cur_data;
    end

    // A simultaneous accept and credit return cancel out.
    if (accept && !credit_in) begin
      credits_d = credits_q - CNT_BITS'(1);
    end else if (credit_in && !accept) begin
      if (credits_q == CNT_BITS'(CREDIT_INIT)) begin
        cerr_d = 1'b1;
      end else begin
        credits_d = credits_q + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      credits_q <= CNT_BITS'(CREDIT_INIT);
      flit_q    <= '0;
      en_q      <= 1'b0;
      cerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      credits_q <= credits_d;
      flit_q    <= flit_d;
      en_q      <= en_d;
      cerr_q    <= cerr_d;
    end
  end

  assign putFlit       = flit_q;
  assign EN_putFlit    = en_q;
  assign EN_getCredits = 1'b1;
  assign grant_id      = grant_q;
  assign busy          = (state_q == SEND);
  assign credit_err    = cerr_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Self-checking bench for noc_inject_arbiter: directed scenarios plus a random
// phase, checked against per-requester flit queues and a round-robin owner model.
module tb_noc_inject_arbiter;

  localparam int N    = 4;
  localparam int DW   = 64;
  localparam int DB   = 5;
  localparam int VB   = 2;
  localparam int TXVC = 0;
  localparam int CI   = 16;
  localparam int CB   = 5;
  localparam int FW   = 2 + DW + DB + VB;

  logic            sys_clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_tail, req_ready;
  logic [N*DB-1:0] req_dest;
  logic [N*DW-1:0] req_data;
  logic [FW-1:0]   putFlit;
  logic            EN_putFlit, EN_getCredits, busy, credit_err;
  logic [VB:0]     getCredits;
  logic [2:0]      grant_id;

  noc_inject_arbiter #(
    .NUM_REQ         (N),
    .FLIT_DATA_WIDTH (DW),
    .DEST_BITS       (DB),
    .VC_BITS         (VB),
    .TX_VC           (TXVC),
    .CREDIT_INIT     (CI),
    .CNT_BITS        (CB)
  ) dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_tail      (req_tail),
    .req_dest      (req_dest),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .putFlit       (putFlit),
    .EN_putFlit    (EN_putFlit),
    .getCredits    (getCredits),
    .EN_getCredits (EN_getCredits),
    .grant_id      (grant_id),
    .busy          (busy),
    .credit_err    (credit_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic          tail;
    logic [DB-1:0] dest;
    logic [DW-1:0] data;
  } flit_t;

  flit_t      q[N][$];
  logic [2:0] gq[$];

  int            m_owner, m_ptr, m_credits, m_grant;
  bit            m_en, m_cerr, prev_busy;
  logic [FW-1:0] m_flit;
  int            n_cmp, n_mis, accepts;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Arbitration winner among the valid requesters, starting at the rr pointer.
  function automatic int pick(input logic [N-1:0] v);
    int c;
`ifdef ARB_PRIO0_EN
    if (v[0]) return 0;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (c != 0 && v[c]) return c;
    end
`else
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_credits = CI; m_grant = 0;
    m_en = 0; m_cerr = 0; m_flit = '0; prev_busy = 0; accepts = 0;
    for (int i = 0; i < N; i++) q[i].delete();
  endtask

  task automatic push_pkt(input int r, input int len, input logic [DB-1:0] dest,
                          input logic [DW-1:0] base);
    flit_t f;
    for (int i = 0; i < len; i++) begin
      f.tail = (i == len - 1);
      f.dest = dest;
      f.data = base + DW'(i);
      q[r].push_back(f);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    reset = 1'b1;
    model_reset();
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  // cmode: 0 no credit, 1 random credit, 2 credit with every accept, 3 force credit.
  task automatic cycle(input int cmode, input int bub);
    logic [N-1:0] exp_rdy;
    bit           acc, cr;
    flit_t        f;
    int           p;
    @(negedge sys_clk);
    exp_rdy = '0;
    if (m_owner >= 0 && m_credits > 0) exp_rdy[m_owner] = 1'b1;
    chk("en_putflit", EN_putFlit, m_en);
    chk("putflit", putFlit, m_flit);
    chk("busy", busy, m_owner >= 0);
    chk("grant_id", grant_id, m_grant);
    chk("req_ready", req_ready, exp_rdy);
    chk("credit_err", credit_err, m_cerr);
    chk("en_getcredits", EN_getCredits, 1'b1);
    chk("credits", dut.credits_q, m_credits);
    if (busy && !prev_busy) gq.push_back(grant_id);
    prev_busy = busy;

    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        f = q[i][0];
        req_valid[i]           = ($urandom_range(99) >= bub);
        req_tail[i]            = f.tail;
        req_dest[i*DB +: DB]   = f.dest;
        req_data[i*DW +: DW]   = f.data;
      end else begin
        req_valid[i]           = 1'b0;
        req_tail[i]            = 1'b0;
        req_dest[i*DB +: DB]   = '0;
        req_data[i*DW +: DW]   = '0;
      end
    end
    acc = (m_owner >= 0) && req_valid[m_owner] && (m_credits > 0);
    case (cmode)
      0:       cr = 0;
      1:       cr = (m_credits < CI) && ($urandom_range(99) < 35);
      2:       cr = acc;
      default: cr = 1;
    endcase
    getCredits = {cr, VB'($urandom)};

    m_en   = acc;
    m_flit = '0;
    f      = '0;
    if (acc) begin
      f      = q[m_owner].pop_front();
      m_flit = {1'b1, f.tail, f.dest, VB'(TXVC), f.data};
      accepts++;
    end
    if (cr && !acc) begin
      if (m_credits == CI) m_cerr = 1;
      else m_credits++;
    end else if (acc && !cr) begin
      m_credits--;
    end
    if (m_owner >= 0) begin
      if (acc && f.tail) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else begin
      p = pick(req_valid);
      if (p >= 0) begin
        m_owner = p;
        m_grant = p;
      end
    end
  endtask

  initial begin
    int left;
    n_cmp = 0; n_mis = 0;
    reset = 1'b1; req_valid = '0; req_tail = '0; req_dest = '0; req_data = '0;
    getCredits = '0;
    model_reset();

    // Reset state, then single requester: 3-flit packet on req1.
    cycle(0, 0);
    push_pkt(1, 3, 5'd5, 64'hA);
    for (int c = 0; c < 6; c++) cycle(0, 0);
    chk("single_credits", dut.credits_q, 13);
    chk("single_drained", q[1].size(), 0);

    // Contention among req0..2 from a fresh pointer.
    do_reset();
    cycle(0, 0);
    gq.delete();
    push_pkt(0, 2, 5'd1, 64'h100);
    push_pkt(1, 2, 5'd2, 64'h200);
    push_pkt(2, 2, 5'd3, 64'h300);
    for (int c = 0; c < 14; c++) cycle(0, 0);
    chk("contend_count", gq.size(), 3);
    for (int i = 0; i < 3 && i < gq.size(); i++) chk("contend_order", gq[i], i);

    // Credit exhaustion: 17 flits, no returns, then a single credit.
    do_reset();
    push_pkt(2, 17, 5'd7, 64'h1000);
    for (int c = 0; c < 22; c++) cycle(0, 0);
    chk("exhaust_credits", dut.credits_q, 0);
    chk("exhaust_ready", req_ready, 0);
    chk("exhaust_left", q[2].size(), 1);
    cycle(3, 0);
    for (int c = 0; c < 3; c++) cycle(0, 0);
    chk("exhaust_drained", q[2].size(), 0);

    // Simultaneous accept and credit, then an overflowing credit.
    do_reset();
    push_pkt(0, 20, 5'd9, 64'h2000);
    for (int c = 0; c < 23; c++) cycle(2, 0);
    chk("simul_credits", dut.credits_q, CI);
    cycle(3, 0);
    cycle(0, 0);
    chk("overflow_err", credit_err, 1'b1);
    chk("overflow_credits", dut.credits_q, CI);

    // Reset after the second flit of a 4-flit packet.
    do_reset();
    push_pkt(1, 4, 5'd4, 64'h3000);
    left = 10;
    while (accepts < 2 && left > 0) begin
      cycle(0, 0);
      left--;
    end
    chk("midrst_reached", accepts, 2);
    do_reset();
    cycle(0, 0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_en", EN_putFlit, 1'b0);
    chk("midrst_credits", dut.credits_q, CI);
    chk("midrst_err", credit_err, 1'b0);

    // Pointer at 3 with req0 and req3 pending.
    do_reset();
    push_pkt(2, 1, 5'd2, 64'h4000);
    for (int c = 0; c < 4; c++) cycle(0, 0);
    gq.delete();
    push_pkt(0, 2, 5'd8, 64'h5000);
    push_pkt(3, 2, 5'd9, 64'h6000);
    for (int c = 0; c < 12; c++) cycle(0, 0);
    chk("prio_count", gq.size(), 2);
    if (gq.size() == 2) begin
`ifdef ARB_PRIO0_EN
      chk("prio_first", gq[0], 0);
      chk("prio_second", gq[1], 3);
`else
      chk("prio_first", gq[0], 3);
      chk("prio_second", gq[1], 0);
`endif
    end

    // Random traffic with bubbles and random credit returns.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int r = 0; r < N; r++)
        if (q[r].size() == 0 && $urandom_range(99) < 20)
          push_pkt(r, $urandom_range(4, 1), DB'($urandom), {$urandom, $urandom});
      cycle(1, 25);
    end
    left = 400;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0 && left > 0) begin
      cycle(1, 0);
      left--;
    end
    chk("random_drained", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
    cycle(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
- Shares one NoC user send port (putFlit/EN_putFlit with credit return) between NUM_REQ local flit sources, e.g. the block-header distributor and PE result/report paths.
- Round-robin, packet-atomic (wormhole) arbitration: once a requester is granted, it keeps the port until its tail flit is sent.
- Owns the single credit counter for the port and assembles the flit word {valid, tail, dest, vc, data}.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FLIT_DATA_WIDTH, 64, payload bits per flit.
- DEST_BITS, 5, destination field width.
- VC_BITS, 2, virtual-channel field width.
- TX_VC, 0, fixed VC stamped on every flit.
- CREDIT_INIT, 16, credits at reset (equals the router flit buffer depth).
- CNT_BITS, 5, credit counter width; must hold CREDIT_INIT.

Ports:
- sys_clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester flit-valid.
- req_tail  in  NUM_REQ  per-requester tail-flit marker.
- req_dest  in  NUM_REQ*DEST_BITS  per-requester destination; requester i occupies slice i.
- req_data  in  NUM_REQ*FLIT_DATA_WIDTH  per-requester payload; requester i occupies slice i.
- req_ready  out  NUM_REQ  flit accepted this cycle when valid&ready.
- putFlit  out  2+FLIT_DATA_WIDTH+DEST_BITS+VC_BITS  flit word to the NoC.
- EN_putFlit  out  1  flit-valid strobe to the NoC.
- getCredits  in  VC_BITS+1  credit return; MSB is valid.
- EN_getCredits  out  1  credit-accept enable; constant 1 after reset.
- grant_id  out  3  index of the current owner.
- busy  out  1  high in SEND state.
- credit_err  out  1  sticky flag: a credit was returned while the counter was already at CREDIT_INIT.

Behaviour:
- Reset values:
  - putFlit=0, EN_putFlit=0, EN_getCredits=1.
  - req_ready=0, grant_id=0, busy=0, credit_err=0.
  - credit counter=CREDIT_INIT, rr pointer=0, state=IDLE.
  - Reset mid-packet discards the packet; no flit is emitted on the reset cycle.
- States:
  - IDLE: if any req_valid, pick the first requester with valid set, searching from rr pointer upward with wrap. Latch grant_id and go to SEND on the next cycle. No flit is accepted in IDLE.
  - SEND: req_ready[grant_id] = (credits>0); all other ready bits are 0.
    - On accept (valid&ready): register putFlit = {1, req_tail, req_dest, TX_VC, req_data} and pulse EN_putFlit=1 in the next cycle. Latency is 1 cycle from accept to EN_putFlit.
    - On accepting a tail flit: rr pointer = grant_id+1 mod NUM_REQ, then go to IDLE.
  - With continuous traffic, back-to-back packets from different requesters are separated by one idle arbitration cycle.
- Flit word:
  - When EN_putFlit=0, putFlit is driven to all zeros.
  - Single-flit packets have tail=1 on the first flit.
- Credits:
  - Decrement on each accept; increment on getCredits[MSB].
  - Accept and credit in the same cycle: counter unchanged.
  - At 0 credits, ready is deasserted and the packet stalls in SEND; the grant is held and no other requester may interleave.
  - Credit returned while counter==CREDIT_INIT: counter holds and credit_err sets until reset.
- Requesters may drop req_valid mid-packet (bubble); the grant is held regardless.
- grant_id only updates on IDLE->SEND transitions.

Optional Feature:
- Macro: ARB_PRIO0_EN.
- Defined: requester 0 has strict priority in IDLE whenever req_valid[0]=1; the round-robin search applies only among requesters 1..NUM_REQ-1. Packet atomicity still holds, so requester 0 never preempts a packet in progress.
- Undefined: pure round-robin across all requesters.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, SEND=2'd1;
  - flit field offsets (VALID_POS, TAIL_POS, DEST_LSB, VC_LSB);
  - credit-valid bit position;
  - default widths taken from the NoC parameter header.
- One sub-module, rr_pick: combinational, given req vector and pointer, returns index and found. It is instantiated once; the ARB_PRIO0_EN masking is done outside it.

Test Plan:
- Single requester: req1 sends a 3-flit packet, dest=5, data 0xA,0xB,0xC -> three EN_putFlit pulses, each 1 cycle after accept; the last has tail=1 and vc=0; credits go 16->13.
- Contention: req0, req1 and req2 all hold 2-flit packets -> grant order 0,1,2; no flit interleaving; 1 idle cycle between packets.
- Credit exhaustion: send 17 flits with no credit return -> ready drops after the 16th accept; 1 cycle after a credit pulse, the 17th flit is accepted.
- Simultaneous accept and credit return over 20 cycles -> counter stays constant; an extra credit at 16 -> credit_err=1 and counter stays 16.
- Reset asserted mid-packet (after flit 2 of 4) -> next cycle: all outputs at reset values, credits=16, state IDLE.
- With ARB_PRIO0_EN defined: req0 and req3 pending with rr pointer=3 -> req0 granted first. Without the macro -> req3 granted first.
